// File: rtl/restoring_divider_16bit.sv
// Sequential unsigned restoring divider, one quotient bit per clock on a full_adder_mux ripple chain.
// Optional macro DIV_ZERO_DETECT_EN: zero divisor completes in one cycle with DivErr set.

module full_adder_mux (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);
    logic p;

    assign p    = a_i ^ b_i;
    assign s_o  = p ^ c_i;
    // Propagate selects the incoming carry, otherwise both inputs agree and generate/kill
    assign co_o = p ? c_i : a_i;
endmodule

module restoring_divider_16bit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivErr
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
`ifdef DIV_ZERO_DETECT_EN
    logic             err_q, err_d;
`endif

    // Trial subtraction T = {R,Qmsb} - {0,D} on a WIDTH+1 cell ripple chain
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   sub_b;
    logic [WIDTH:0]   t;
    logic [WIDTH+1:0] c;
    logic             no_borrow;
    logic [WIDTH:0]   r_new_full;
    logic [WIDTH-1:0] r_new;
    logic [WIDTH-1:0] q_new;
    logic             unused_r_msb;

    assign r_sh  = {r_q, q_q[WIDTH-1]};
    assign sub_b = ~{1'b0, d_q};
    assign c[0]  = 1'b1;

    for (genvar i = 0; i < WIDTH + 1; i++) begin : g_chain
        full_adder_mux u_fa (
            .a_i  (r_sh[i]),
            .b_i  (sub_b[i]),
            .c_i  (c[i]),
            .s_o  (t[i]),
            .co_o (c[i+1])
        );
    end

    assign no_borrow  = c[WIDTH+1];
    assign r_new_full = no_borrow ? t : r_sh;
    // The restored partial remainder is always below D, so its MSB is always 0
    assign r_new        = r_new_full[WIDTH-1:0];
    assign unused_r_msb = r_new_full[WIDTH];
    assign q_new        = {q_q[WIDTH-2:0], no_borrow};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
`ifdef DIV_ZERO_DETECT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
`ifdef DIV_ZERO_DETECT_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
`ifdef DIV_ZERO_DETECT_EN
        err_d   = err_q;
`endif
        case (state_q)
            S_RUN: begin
                r_d   = r_new;
                q_d   = q_new;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    quo_d   = q_new;
                    rem_d   = r_new;
`ifdef DIV_ZERO_DETECT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (Start) begin
                    state_d = S_RUN;
                    d_d     = Divisor;
                    q_d     = Dividend;
                    r_d     = '0;
                    cnt_d   = CW'(WIDTH);
`ifdef DIV_ZERO_DETECT_EN
                    if (Divisor == '0) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                        quo_d   = '1;
                        rem_d   = Dividend;
                        err_d   = 1'b1;
                    end
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign Busy      = (state_q == S_RUN);
    assign Done      = (state_q == S_DONE);
    assign Quotient  = quo_q;
    assign Remainder = rem_q;
`ifdef DIV_ZERO_DETECT_EN
    assign DivErr    = err_q;
`else
    assign DivErr    = 1'b0;
`endif

endmodule

// File: tb/tb_restoring_divider_16bit.sv
// Directed bench for restoring_divider_16bit with a queue scoreboard of expected results.
// Honours DIV_ZERO_DETECT_EN to select the zero-divisor expectations.

module tb_restoring_divider_16bit;
    localparam int unsigned W = 16;
`ifdef DIV_ZERO_DETECT_EN
    localparam bit DZ = 1'b1;
`else
    localparam bit DZ = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         Start;
    logic [W-1:0] Dividend;
    logic [W-1:0] Divisor;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;
    logic         DivErr;

    restoring_divider_16bit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .Start     (Start),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Busy      (Busy),
        .Done      (Done),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .DivErr    (DivErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         err;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] held_q = '0;
    logic [W-1:0] held_r = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Drive a request at a negedge; the following posedge is the accepting edge k
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        exp_t e;
        Start    = 1'b1;
        Dividend = a;
        Divisor  = b;
        if (push) begin
            e.q   = (b == '0) ? '1 : a / b;
            e.r   = (b == '0) ? a  : a % b;
            e.err = DZ && (b == '0);
            e.lat = (DZ && (b == '0)) ? 1 : int'(W) + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        Start    = 1'b0;
        Dividend = W'($urandom);
        Divisor  = W'($urandom);
    endtask

    // Sample at negedge n after edge k: the value seen at edge k+n; optional Start poke at cycle 'poke'
    task automatic expect_done(input string tag, input int poke);
        exp_t e;
        int   cyc;
        cyc = 1;
        e   = sb.pop_front();
        while (Done !== 1'b1 && cyc < 40) begin
            chk({tag, " busy"}, 32'(Busy), 32'd1);
            if (cyc == e.lat - 1) begin
                chk({tag, " held_q"}, 32'(Quotient), 32'(held_q));
                chk({tag, " held_r"}, 32'(Remainder), 32'(held_r));
            end
            if (cyc == poke) begin
                Start    = 1'b1;
                Dividend = 16'd9;
                Divisor  = 16'd2;
            end else begin
                Start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        Start = 1'b0;
        chk({tag, " latency"}, 32'(cyc), 32'(e.lat));
        chk({tag, " done"}, 32'(Done), 32'd1);
        chk({tag, " busy_at_done"}, 32'(Busy), 32'd0);
        chk({tag, " quotient"}, 32'(Quotient), 32'(e.q));
        chk({tag, " remainder"}, 32'(Remainder), 32'(e.r));
        chk({tag, " diverr"}, 32'(DivErr), 32'(e.err));
        held_q = e.q;
        held_r = e.r;
    endtask

    task automatic pulse_end(input string tag);
        @(negedge clk);
        chk({tag, " done_pulse_end"}, 32'(Done), 32'd0);
        chk({tag, " idle_busy"}, 32'(Busy), 32'd0);
        chk({tag, " result_hold"}, 32'(Quotient), 32'(held_q));
    endtask

    initial begin
        bit seen;
        rst      = 1'b1;
        Start    = 1'b1;
        Dividend = 16'd3;
        Divisor  = 16'd1;
        repeat (2) @(negedge clk);
        chk("reset busy", 32'(Busy), 32'd0);
        chk("reset done", 32'(Done), 32'd0);
        chk("reset quotient", 32'(Quotient), 32'd0);
        chk("reset remainder", 32'(Remainder), 32'd0);
        chk("reset diverr", 32'(DivErr), 32'd0);
        rst   = 1'b0;
        Start = 1'b0;
        @(negedge clk);
        chk("start_in_reset ignored", 32'(Busy), 32'd0);

        start_op(16'd100, 16'd7, 1'b1);
        expect_done("100/7", 0);
        pulse_end("100/7");

        start_op(16'hFFFF, 16'h0001, 1'b1);
        expect_done("ffff/1", 0);
        pulse_end("ffff/1");

        start_op(16'd5, 16'd9, 1'b1);
        expect_done("5/9", 0);
        pulse_end("5/9");

        start_op(16'hFFFF, 16'hFFFF, 1'b1);
        expect_done("ffff/ffff", 0);
        pulse_end("ffff/ffff");

        start_op(16'h1234, 16'h0000, 1'b1);
        expect_done("1234/0", 0);
        pulse_end("1234/0");

        start_op(16'd1000, 16'd3, 1'b1);
        expect_done("1000/3 start_ignored", 4);
        pulse_end("1000/3");

        // Abort an operation with reset at cycle 8
        start_op(16'hABCD, 16'd3, 1'b0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrun reset busy", 32'(Busy), 32'd0);
        chk("midrun reset done", 32'(Done), 32'd0);
        chk("midrun reset quotient", 32'(Quotient), 32'd0);
        chk("midrun reset remainder", 32'(Remainder), 32'd0);
        chk("midrun reset diverr", 32'(DivErr), 32'd0);
        held_q = '0;
        held_r = '0;
        seen   = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (Done === 1'b1) seen = 1'b1;
        end
        chk("midrun reset no_done", 32'(seen), 32'd0);

        start_op(16'd50, 16'd5, 1'b1);
        expect_done("50/5", 0);
        pulse_end("50/5");

        // Back-to-back: Start held during the Done cycle
        start_op(16'd200, 16'd9, 1'b1);
        expect_done("b2b first", 0);
        start_op(16'd77, 16'd10, 1'b1);
        expect_done("b2b second", 0);
        pulse_end("b2b second");

        chk("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
